// File: rtl/ram_pkg.sv
// Shared constants and state encoding for the RAM stream reader.
package ram_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned RAM_DEPTH  = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } rd_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO holding RAM words until the consumer accepts them.
module stream_skid_buf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot being written.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem_q[rd_ptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a burst of consecutive RAM words (wrapping) and streams them out with
// valid/ready handshaking through a 2-entry buffer.
module ram_stream_reader
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_do,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned    Depth   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FullLen = (ADDR_W + 1)'(Depth);
  localparam logic [ADDR_W:0] OneLeft = (ADDR_W + 1)'(1);

  rd_state_e         state;
  logic [ADDR_W-1:0] nxt_addr;
  logic [ADDR_W:0]   issue_left;
  logic [ADDR_W:0]   xfer_left;
  logic              inflight;
  logic [ADDR_W:0]   burst_len;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        occ;
  logic              pop;
  logic              can_issue;

  assign burst_len = (count == '0) ? FullLen : count;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign occ       = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  // Never let buffered plus returning words exceed the two FIFO slots.
  assign can_issue = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      ram_addr   <= '0;
      nxt_addr   <= '0;
      issue_left <= '0;
      xfer_left  <= '0;
      inflight   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      inflight <= 1'b0;
      done     <= 1'b0;
      if (pop) begin
        xfer_left <= xfer_left - 1'b1;
      end
      case (state)
        StIdle: begin
          if (start) begin
            nxt_addr   <= base_addr;
            issue_left <= burst_len;
            xfer_left  <= burst_len;
            busy       <= 1'b1;
            state      <= StRead;
          end
        end
        StRead: begin
          if (can_issue) begin
            ram_addr   <= nxt_addr;
            nxt_addr   <= nxt_addr + 1'b1;
            inflight   <= 1'b1;
            issue_left <= issue_left - 1'b1;
            if (issue_left == OneLeft) begin
              state <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pop && (xfer_left == OneLeft)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  stream_skid_buf #(
    .WIDTH(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(ram_do),
    .pop      (pop),
    .head     (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed and randomized bursts checked against a queue-based model of the stream.
module tb_ram_stream_reader;

  localparam int unsigned DW    = 4;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_do;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign ram_do = mem[ram_addr];

  ram_stream_reader #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .ram_addr (ram_addr),
    .ram_do   (ram_do),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // mode: 0 ready high, 1 ready toggles, 2 random ready, 3 ready low for 5 cycles.
  task automatic run_burst(input int base, input int cnt, input int mode, input bit mid,
                           input int abort_after);
    logic [DW-1:0] q[$];
    logic [AW-1:0] idx;
    logic [DW-1:0] prev_data;
    int            n;
    int            xfers;
    int            first_k;
    int            last_k;
    bit            seen_done;
    bit            prev_stall;
    bit            rdy;
    n = (cnt == 0) ? DEPTH : cnt;
    for (int i = 0; i < n; i++) begin
      idx = AW'(base + i);
      q.push_back(mem[idx]);
    end
    start     = 1'b1;
    base_addr = AW'(base);
    count     = (AW + 1)'(cnt);
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    xfers      = 0;
    first_k    = -1;
    last_k     = -1;
    prev_stall = 1'b0;
    prev_data  = '0;
    seen_done  = 1'b0;
    for (int k = 0; k < 80 && !seen_done; k++) begin
      if (k > 0) @(negedge clk);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 2 == 0);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (k >= 5);
      endcase
      out_ready = rdy;
      if (mid && k == 3) begin
        start     = 1'b1;
        base_addr = 3'd5;
        count     = 4'd1;
      end else begin
        start = 1'b0;
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (done) begin
        seen_done = 1'b1;
        chk("xfer_count", xfers, n);
        chk("done_after_last", k, last_k + 1);
        chk("valid_in_done", out_valid, 0);
        if (mode == 0) begin
          chk("first_latency", first_k, 2);
          chk("no_bubbles", last_k - first_k + 1, n);
        end
      end else begin
        chk("busy", busy, 1);
        if (out_valid && rdy) begin
          if (q.size() == 0) chk("extra_xfer", q.size(), 1);
          else chk("data", out_data, q.pop_front());
          if (first_k < 0) first_k = k;
          last_k = k;
          xfers++;
          if (abort_after > 0 && xfers == abort_after) begin
            @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            @(negedge clk);
            rst = 1'b0;
            return;
          end
        end
        prev_stall = out_valid && !rdy;
        prev_data  = out_data;
      end
    end
    if (!seen_done) chk("timeout", seen_done, 1);
  endtask

  // Called at the DONE-cycle sample; optionally raises start there (must be ignored).
  task automatic post_done(input bit restart, input int base, input int cnt);
    if (restart) begin
      start     = 1'b1;
      base_addr = AW'(base);
      count     = (AW + 1)'(cnt);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    base_addr = '0;
    count     = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_addr", ram_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    run_burst(0, 0, 0, 1'b0, 0);
    post_done(1'b0, 0, 0);
    run_burst(6, 4, 0, 1'b0, 0);
    post_done(1'b1, 0, 8);
    run_burst(0, 8, 1, 1'b0, 0);
    post_done(1'b0, 0, 0);
    run_burst(0, 8, 0, 1'b1, 0);
    post_done(1'b0, 0, 0);
    run_burst(0, 8, 0, 1'b0, 3);
    @(negedge clk);
    run_burst(0, 2, 0, 1'b0, 0);
    post_done(1'b0, 0, 0);
    run_burst(5, 1, 3, 1'b0, 0);
    post_done(1'b0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 15));
      run_burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)), 2, 1'b0, 0);
      post_done(1'b0, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
